// File: rtl/timer_pkg.sv
// Shared constants and helpers for the two-stage interval timer.
// Build option TIMER_BCD_CLAMP_EN: limit/compare nibbles above 9 act as 9.

package timer_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ADDR_SS = 2'b00;
    localparam logic [1:0] ADDR_T1 = 2'b01;
    localparam logic [1:0] ADDR_T2 = 2'b10;

    localparam logic [7:0] SS_DEF = 8'h00;
    localparam logic [7:0] T_DEF  = 8'h99;

    localparam int RUN_BIT = 0;
    localparam int CLR_BIT = 7;

    // CLR is a strobe, never stored
    localparam logic [7:0] CLR_MASK = 8'h80;

    typedef logic [NIB_W-1:0] nib_t;

    // Value a stored nibble takes when used as a limit or compare point
    function automatic nib_t nib_eff(input nib_t n);
`ifdef TIMER_BCD_CLAMP_EN
        return (n > 4'd9) ? 4'd9 : n;
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/timer_nib_counter.sv
// 4-bit wrapping counter: counts on en, wraps to 0 once count >= limit.
// Ports: clk, rst_n (sync, active-low), en, clr, limit[3:0] -> count[3:0], wrap.

module timer_nib_counter
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic [3:0] count,
    output logic       wrap
);

    // >= rather than == so a limit lowered under the count wraps next tick
    assign wrap = en && !clr && (count >= limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 4'd1;
        end
    end

endmodule

// File: rtl/timer_core.sv
// Register-programmed two-stage interval timer (tout_10 base, tout_100 long).
// Ports: clk, rst_n (sync, active-low), sel (0: tick/clk, 1: tick/2 clk),
//   write, read, addr[1:0], wdata[7:0] -> rdata[7:0]; tout_10, tout_100 pulses.
// Build option TIMER_BCD_CLAMP_EN: clamp LIM1/LIM2/CMP nibbles to 9.

module timer_core
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic       write,
    input  logic       read,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tout_10,
    output logic       tout_100
);

    logic [7:0] ss;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       tog;
    logic       tick;
    logic       run;
    logic       clr;

    logic [3:0] lim1;
    logic [3:0] lim2;
    logic [3:0] cmp_raw;
    logic [3:0] cmp;

    logic [3:0] unused_cnt1;
    logic [3:0] cnt2;
    logic       wrap1;
    logic       unused_wrap2;

    // CLR acts on the write edge itself, so counting never sees it late
    assign clr = write && (addr == ADDR_SS) && wdata[CLR_BIT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss <= SS_DEF;
            t1 <= T_DEF;
            t2 <= T_DEF;
        end else if (write) begin
            case (addr)
                ADDR_SS: ss <= wdata & ~CLR_MASK;
                ADDR_T1: t1 <= wdata;
                ADDR_T2: t2 <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog <= 1'b0;
        end else begin
            tog <= ~tog;
        end
    end

    assign tick = sel ? tog : 1'b1;
    assign run  = ss[RUN_BIT];

    assign lim1    = nib_eff(t1[3:0]);
    assign lim2    = nib_eff(t1[7:4]);
    assign cmp_raw = nib_eff(t2[3:0]);
    assign cmp     = (cmp_raw > lim2) ? lim2 : cmp_raw;

    timer_nib_counter u_cnt1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run && tick),
        .clr   (clr),
        .limit (lim1),
        .count (unused_cnt1),
        .wrap  (wrap1)
    );

    timer_nib_counter u_cnt2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wrap1),
        .clr   (clr),
        .limit (lim2),
        .count (cnt2),
        .wrap  (unused_wrap2)
    );

    assign tout_10  = wrap1;
    assign tout_100 = wrap1 && (cnt2 == cmp);

    always_comb begin
        rdata = 8'h00;
        if (read) begin
            case (addr)
                ADDR_SS: rdata = ss;
                ADDR_T1: rdata = t1;
                ADDR_T2: rdata = t2;
                default: rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: directed scenarios plus random bus
// traffic compared against a behavioural model of the register/timer rules.

`timescale 1ns/1ps

module tb_timer_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [1:0] addr = 2'b00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       tout_10;
    logic       tout_100;

    int checks = 0;
    int errors = 0;

    timer_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .write    (write),
        .read     (read),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tout_10  (tout_10),
        .tout_100 (tout_100)
    );

    always #500 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_reg [0:3];
    bit         m_tog;
    int         c1;
    int         c2;
    longint     t_wr;

    function automatic int eff(input int n);
`ifdef TIMER_BCD_CLAMP_EN
        return (n > 9) ? 9 : n;
`else
        return n;
`endif
    endfunction

    function automatic int m_lim1();
        return eff(int'(m_reg[1][3:0]));
    endfunction

    function automatic int m_lim2();
        return eff(int'(m_reg[1][7:4]));
    endfunction

    function automatic int m_cmp();
        int c;
        c = eff(int'(m_reg[2][3:0]));
        return (c < m_lim2()) ? c : m_lim2();
    endfunction

    function automatic bit m_clr();
        return write && (addr == 2'b00) && wdata[7];
    endfunction

    function automatic bit m_counting();
        return m_reg[0][0] && (sel ? m_tog : 1'b1) && !m_clr();
    endfunction

    function automatic bit e10();
        return m_counting() && (c1 >= m_lim1());
    endfunction

    function automatic bit e100();
        return e10() && (c2 == m_cmp());
    endfunction

    function automatic logic [7:0] erd();
        return read ? m_reg[addr] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_reg[0] = 8'h00;
            m_reg[1] = 8'h99;
            m_reg[2] = 8'h99;
            m_reg[3] = 8'h00;
            m_tog = 1'b0;
            c1 = 0;
            c2 = 0;
        end else begin
            if (m_clr()) begin
                c1 = 0;
                c2 = 0;
            end else if (m_counting()) begin
                if (c1 >= m_lim1()) begin
                    c1 = 0;
                    c2 = (c2 >= m_lim2()) ? 0 : c2 + 1;
                end else begin
                    c1 = c1 + 1;
                end
            end
            m_tog = !m_tog;
            if (write && addr != 2'b11)
                m_reg[addr] = (addr == 2'b00) ? (wdata & 8'h7F) : wdata;
        end
    end

    // ---------------- bus driver ----------------
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        write = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        t_wr = longint'($time);
        @(negedge clk);
        write = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset(input string nm);
        logic [7:0] want [0:3];
        bit any_high;
        want[0] = 8'h00;
        want[1] = 8'h99;
        want[2] = 8'h99;
        want[3] = 8'h00;
        write = 1'b0;
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (tout_10 !== 1'b0 || tout_100 !== 1'b0) begin
            errors++;
            $display("FAIL %s out_in_reset got %b%b want 00", nm, tout_10, tout_100);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            read = 1'b1;
            addr = 2'(i);
            #1;
            checks++;
            if (rdata !== want[i]) begin
                errors++;
                $display("FAIL %s rd_%0d got %h want %h", nm, i, rdata, want[i]);
            end
            read = 1'b0;
        end
        any_high = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (tout_10 !== 1'b0 || tout_100 !== 1'b0)
                any_high = 1'b1;
        end
        checks++;
        if (any_high) begin
            errors++;
            $display("FAIL %s idle_outputs got pulse want none", nm);
        end
    endtask

    // Checks against the model every cycle and measures pulse periods in us
    task automatic measure(input string nm, input int p10, input int p100);
        longint t10 [$];
        longint t100 [$];
        int n;
        int bound;
        n = 0;
        bound = 3 * p100 + 100;
        while ((t10.size() < 3 || t100.size() < 2) && n < bound) begin
            @(negedge clk);
            #1;
            n++;
            if (tout_10 === 1'b1) t10.push_back(longint'($time));
            if (tout_100 === 1'b1) t100.push_back(longint'($time));
            checks++;
            if (tout_10 !== e10() || tout_100 !== e100()) begin
                errors++;
                $display("FAIL %s model_cyc%0d got %b%b want %b%b",
                         nm, n, tout_10, tout_100, e10(), e100());
            end
        end
        checks++;
        if (t10.size() < 3 || t100.size() < 2) begin
            errors++;
            $display("FAIL %s timeout got %0d/%0d pulses want 3/2",
                     nm, t10.size(), t100.size());
        end else begin
            checks++;
            if (t10[2] - t10[1] != longint'(p10) * 1000) begin
                errors++;
                $display("FAIL %s period10 got %0d ns want %0d ns",
                         nm, t10[2] - t10[1], p10 * 1000);
            end
            checks++;
            if (t100[1] - t100[0] != longint'(p100) * 1000) begin
                errors++;
                $display("FAIL %s period100 got %0d ns want %0d ns",
                         nm, t100[1] - t100[0], p100 * 1000);
            end
        end
    endtask

    task automatic rd_check(input string nm, input logic [1:0] a, input logic [7:0] want);
        @(negedge clk);
        read = 1'b1;
        addr = a;
        #1;
        checks++;
        if (rdata !== want) begin
            errors++;
            $display("FAIL %s rd_%0d got %h want %h", nm, a, rdata, want);
        end
        read = 1'b0;
    endtask

    task automatic test_default_run();
        sel = 1'b0;
        wr(2'b00, 8'h01);
        measure("default", 10, 100);
    endtask

    task automatic test_clr_limits();
        wr(2'b00, 8'h80);
        rd_check("clr", 2'b00, 8'h00);
        wr(2'b00, 8'h01);
        rd_check("run", 2'b00, 8'h01);
        wr(2'b01, 8'h49);
        wr(2'b10, 8'h09);
        rd_check("t1", 2'b01, 8'h49);
        rd_check("t2", 2'b10, 8'h09);
        measure("lim49", 10, 50);
    endtask

    task automatic test_sel();
        wr(2'b00, 8'h80);
        wr(2'b01, 8'h99);
        wr(2'b10, 8'h99);
        wr(2'b00, 8'h01);
        sel = 1'b1;
        measure("sel1", 20, 200);
        sel = 1'b0;
    endtask

    task automatic test_pause();
        longint t0;
        longint t1v;
        longint ta;
        int n;
        bit bad;
        int k;
        wr(2'b00, 8'h81);
        n = 0;
        while (tout_10 !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (tout_10 !== 1'b1) begin
            errors++;
            $display("FAIL pause first_pulse got none want pulse");
        end else begin
            t0 = longint'($time);
            k = $urandom_range(1, 7);
            repeat (k) @(negedge clk);
            wr(2'b00, 8'h00);
            ta = t_wr;
            bad = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                #1;
                if (tout_10 !== 1'b0 || tout_100 !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL pause stopped_outputs got pulse want none");
            end
            wr(2'b00, 8'h01);
            n = 0;
            while (tout_10 !== 1'b1 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            t1v = longint'($time);
            checks++;
            if (tout_10 !== 1'b1 || t1v - t0 != 10000 + (t_wr - ta)) begin
                errors++;
                $display("FAIL pause resume got %0d ns want %0d ns",
                         t1v - t0, 10000 + (t_wr - ta));
            end
        end
    endtask

    task automatic test_limit_lower();
        bit want [0:2];
        want[0] = 1'b0;
        want[1] = 1'b0;
        want[2] = 1'b1;
        wr(2'b00, 8'h80);
        wr(2'b01, 8'h98);
        wr(2'b00, 8'h01);
        repeat (4) @(negedge clk);
        wr(2'b01, 8'h92);
        checks++;
        if (tout_10 !== 1'b1) begin
            errors++;
            $display("FAIL lower wrap_now got %b want 1", tout_10);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (tout_10 !== want[i]) begin
                errors++;
                $display("FAIL lower after_%0d got %b want %b", i, tout_10, want[i]);
            end
        end
    endtask

    task automatic test_ff();
        wr(2'b00, 8'h80);
        wr(2'b01, 8'hFF);
        wr(2'b10, 8'h99);
        wr(2'b11, 8'h5A);
        wr(2'b00, 8'h01);
        rd_check("ff", 2'b01, 8'hFF);
        rd_check("ff", 2'b11, 8'h00);
        rd_check("ff", 2'b10, 8'h99);
`ifdef TIMER_BCD_CLAMP_EN
        measure("ff", 10, 100);
`else
        measure("ff", 16, 256);
`endif
    endtask

    task automatic test_random();
        wr(2'b00, 8'h81);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            sel = 1'($urandom_range(0, 1));
            read = 1'($urandom_range(0, 1));
            addr = 2'($urandom_range(0, 3));
            write = ($urandom_range(0, 7) == 0);
            wdata = 8'($urandom);
            if (addr == 2'b00) begin
                wdata[0] = ($urandom_range(0, 7) != 0);
                wdata[7] = ($urandom_range(0, 3) == 0);
            end
            #1;
            checks++;
            if (tout_10 !== e10() || tout_100 !== e100() || rdata !== erd()) begin
                errors++;
                $display("FAIL random cyc%0d got %b%b/%h want %b%b/%h", i,
                         tout_10, tout_100, rdata, e10(), e100(), erd());
            end
        end
        @(negedge clk);
        write = 1'b0;
        read = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        // write and read the same register in one cycle: old value seen
        wr(2'b10, 8'h3C);
        @(negedge clk);
        write = 1'b1;
        read = 1'b1;
        addr = 2'b10;
        wdata = 8'hC3;
        #1;
        checks++;
        if (rdata !== 8'h3C) begin
            errors++;
            $display("FAIL b2b same_cycle got %h want 3c", rdata);
        end
        @(negedge clk);
        write = 1'b0;
        #1;
        checks++;
        if (rdata !== 8'hC3) begin
            errors++;
            $display("FAIL b2b next_cycle got %h want c3", rdata);
        end
        read = 1'b0;
    endtask

    initial begin
        test_reset("reset");
        test_default_run();
        test_clr_limits();
        test_sel();
        test_pause();
        test_limit_lower();
        test_ff();
        test_random();
        test_back_to_back();
        wr(2'b00, 8'h01);
        repeat (7) @(negedge clk);
        test_reset("reset_midrun");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
